// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock/reset sequencing path.
// The state encoding is visible on the debug STATE port, so keep it fixed.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Bits needed to hold every value from 0 up to max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchroniser for an asynchronous status level, cleared by async reset.
// Latency: STAGES clock edges. Backpressure: none, free-running.
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// Stretches reset, waits for a stable clock-manager lock, then releases NUM_RST domains in turn.
// Latency: lock loss reaches the outputs SYNC_STAGES+1 edges after LOCKED_IN falls; all outputs registered.
// Backpressure: none; sw_rst_req is a level sampled on every edge.
module clock_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int NUM_RST        = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int LOCK_STABLE    = 64,
  parameter int STAGGER_CYCLES = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               locked_in,
  input  logic               sw_rst_req,
  output logic [NUM_RST-1:0] rst_out_n,
  output logic               rst_done,
  output logic [CNT_W-1:0]   lock_loss_cnt,
  output logic [1:0]         state
);

  localparam int STRETCH_W = cnt_width(STRETCH_CYCLES);
  localparam int STABLE_W  = cnt_width(LOCK_STABLE);
  localparam int LAST_REL  = (NUM_RST - 1) * STAGGER_CYCLES;
  localparam int REL_W     = cnt_width(LAST_REL);
  localparam logic [CNT_W-1:0] LOSS_MAX = '1;

  seq_state_e           state_q, state_d;
  logic [STRETCH_W-1:0] stretch_q, stretch_d;
  logic [STABLE_W-1:0]  stable_q, stable_d;
  logic [REL_W-1:0]     rel_q, rel_d;
  logic [NUM_RST-1:0]   rst_out_q, rst_out_d;
  logic [CNT_W-1:0]     loss_q, loss_d;
  logic                 done_q;
  logic                 lock_s;
  logic                 lock_lost;

  lock_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (locked_in),
    .sync_out (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    stable_d  = stable_q;
    rel_d     = rel_q;
    rst_out_d = rst_out_q;
    loss_d    = loss_q;
    lock_lost = !lock_s && (state_q == RELEASE || state_q == RUN);

    if (lock_lost && loss_q != LOSS_MAX) begin
      loss_d = loss_q + 1'b1;
    end

    // Software request and lock loss share one path so a coincident pair counts once.
    if (sw_rst_req || lock_lost) begin
      state_d   = HOLD;
      stretch_d = '0;
      stable_d  = '0;
      rel_d     = '0;
      rst_out_d = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          rst_out_d = '0;
          if (stretch_q == STRETCH_W'(STRETCH_CYCLES)) begin
            state_d   = WAIT_LOCK;
            stretch_d = '0;
            stable_d  = '0;
          end else begin
            stretch_d = stretch_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (!lock_s) begin
            stable_d = '0;
          end else if (stable_q == STABLE_W'(LOCK_STABLE - 1)) begin
            state_d      = RELEASE;
            stable_d     = '0;
            rst_out_d[0] = 1'b1;
            if (STAGGER_CYCLES == 0) begin
              rst_out_d = '1;
            end
            // rel counts edges since entry; the entry edge itself is slot 0.
            rel_d = (LAST_REL == 0) ? '0 : REL_W'(1);
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end
        RELEASE: begin
          for (int i = 0; i < NUM_RST; i++) begin
            if (int'(rel_q) == i * STAGGER_CYCLES) begin
              rst_out_d[i] = 1'b1;
            end
          end
          if (rst_out_q[NUM_RST-1]) begin
            state_d = RUN;
          end else if (int'(rel_q) != LAST_REL) begin
            rel_d = rel_q + 1'b1;
          end
        end
        RUN: begin
          rst_out_d = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      stretch_q <= '0;
      stable_q  <= '0;
      rel_q     <= '0;
      rst_out_q <= '0;
      loss_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stretch_q <= stretch_d;
      stable_q  <= stable_d;
      rel_q     <= rel_d;
      rst_out_q <= rst_out_d;
      loss_q    <= loss_d;
      done_q    <= (state_d == RUN);
    end
  end

  assign rst_out_n     = rst_out_q;
  assign rst_done      = done_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer: a default-parameter instance and a zero-stagger, 2-bit-counter instance
// share stimulus; a phase/time reference model tracks both.
module tb_clock_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       locked_in = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] rst_a, rst_z;
  logic       done_a, done_z;
  logic [7:0] cnt_a;
  logic [1:0] cnt_z;
  logic [1:0] state_a, state_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_reset_sequencer #(
    .NUM_RST(4), .STRETCH_CYCLES(16), .LOCK_STABLE(64),
    .STAGGER_CYCLES(8), .SYNC_STAGES(2), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .locked_in(locked_in), .sw_rst_req(sw_rst_req),
    .rst_out_n(rst_a), .rst_done(done_a), .lock_loss_cnt(cnt_a), .state(state_a)
  );

  clock_reset_sequencer #(
    .NUM_RST(4), .STRETCH_CYCLES(16), .LOCK_STABLE(64),
    .STAGGER_CYCLES(0), .SYNC_STAGES(2), .CNT_W(2)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .locked_in(locked_in), .sw_rst_req(sw_rst_req),
    .rst_out_n(rst_z), .rst_done(done_z), .lock_loss_cnt(cnt_z), .state(state_z)
  );

  // Reference model: phase (0 hold,1 wait,2 release,3 run), time within phase, lock seen via a delay queue.
  int p_stag[2] = '{8, 0};
  int p_max[2]  = '{255, 3};
  int m_ph[2], m_t[2], m_stable[2], m_rel[2], m_cnt[2];
  int hist[$];
  int lk;
  bit lost;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_ph[k] = 0; m_t[k] = 0; m_stable[k] = 0; m_rel[k] = 0; m_cnt[k] = 0;
        end
        hist.delete();
        hist.push_back(0);
        hist.push_back(0);
      end else begin
        lk = hist.pop_front();
        hist.push_back(locked_in ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
          lost = (lk == 0) && (m_ph[k] >= 2);
          if (lost && m_cnt[k] < p_max[k]) m_cnt[k]++;
          if (sw_rst_req || lost) begin
            m_ph[k] = 0; m_t[k] = 0;
          end else begin
            case (m_ph[k])
              0: if (m_t[k] == 16) begin m_ph[k] = 1; m_stable[k] = 0; end else m_t[k]++;
              1: begin
                m_stable[k] = (lk != 0) ? m_stable[k] + 1 : 0;
                if (m_stable[k] == 64) begin m_ph[k] = 2; m_rel[k] = 0; end
              end
              2: if (m_rel[k] >= 3 * p_stag[k]) m_ph[k] = 3; else m_rel[k]++;
              default: ;
            endcase
          end
        end
      end
    end
  end

  function automatic logic [3:0] exp_rst(int k);
    logic [3:0] m;
    m = '0;
    if (m_ph[k] == 3) m = '1;
    else if (m_ph[k] == 2)
      for (int i = 0; i < 4; i++) if (i * p_stag[k] <= m_rel[k]) m[i] = 1'b1;
    return m;
  endfunction

  // Continuous scoreboard against the model.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (rst_a !== exp_rst(0) || state_a !== 2'(m_ph[0]) || done_a !== (m_ph[0] == 3) || cnt_a !== 8'(m_cnt[0])) begin
        errors++;
        $display("FAIL monitor_a t=%0t: got rst=%b st=%0d done=%b cnt=%0d required rst=%b st=%0d done=%0d cnt=%0d",
                 $time, rst_a, state_a, done_a, cnt_a, exp_rst(0), m_ph[0], m_ph[0] == 3, m_cnt[0]);
      end
      checks++;
      if (rst_z !== exp_rst(1) || state_z !== 2'(m_ph[1]) || done_z !== (m_ph[1] == 3) || cnt_z !== 2'(m_cnt[1])) begin
        errors++;
        $display("FAIL monitor_z t=%0t: got rst=%b st=%0d done=%b cnt=%0d required rst=%b st=%0d done=%0d cnt=%0d",
                 $time, rst_z, state_z, done_z, cnt_z, exp_rst(1), m_ph[1], m_ph[1] == 3, m_cnt[1]);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    locked_in = 1'b1; sw_rst_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rst_a !== 4'h0 || done_a !== 1'b0 || cnt_a !== 8'd0 || state_a !== 2'd0) begin
      errors++;
      $display("FAIL reset_a: rst=%b done=%b cnt=%0d st=%0d required 0000/0/0/0", rst_a, done_a, cnt_a, state_a);
    end
    checks++;
    if (rst_z !== 4'h0 || done_z !== 1'b0 || cnt_z !== 2'd0 || state_z !== 2'd0) begin
      errors++;
      $display("FAIL reset_z: rst=%b done=%b cnt=%0d st=%0d required 0000/0/0/0", rst_z, done_z, cnt_z, state_z);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rst_a !== 4'h0 || state_a !== 2'd0) begin
      errors++;
      $display("FAIL reset_held: rst=%b st=%0d required 0000/0", rst_a, state_a);
    end
  endtask

  task automatic test_default_sequence();
    locked_in = 1'b1;
    do_reset();
    for (int e = 0; e <= 106; e++) begin
      @(negedge clk);
      if (e == 15 || e == 16 || e == 79 || e == 80 || e == 105) begin
        int want;
        want = (e == 15) ? 0 : (e == 80) ? 2 : (e == 105) ? 3 : 1;
        checks++;
        if (state_a !== 2'(want)) begin
          errors++;
          $display("FAIL default_state edge %0d: got %0d required %0d", e, state_a, want);
        end
      end
      if (e == 79 || e == 80 || e == 87 || e == 88 || e == 96 || e == 104) begin
        logic [3:0] w;
        w = (e == 79) ? 4'b0000 : (e == 88) ? 4'b0011 : (e == 96) ? 4'b0111 : (e == 104) ? 4'b1111 : 4'b0001;
        checks++;
        if (rst_a !== w) begin
          errors++;
          $display("FAIL default_release edge %0d: got %b required %b", e, rst_a, w);
        end
      end
      if (e == 104 || e == 105) begin
        checks++;
        if (done_a !== (e == 105) || cnt_a !== 8'd0) begin
          errors++;
          $display("FAIL default_done edge %0d: done=%b cnt=%0d required done=%0d cnt=0", e, done_a, cnt_a, e == 105);
        end
      end
    end
  endtask

  task automatic test_lock_glitch();
    int g, w, rel;
    g = $urandom_range(20, 70);
    w = $urandom_range(1, 3);
    rel = g + w + 65;
    locked_in = 1'b1;
    do_reset();
    for (int e = 0; e <= rel + 2; e++) begin
      locked_in = (e >= g && e < g + w) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (e == 80 || e == rel - 1 || e == rel) begin
        checks++;
        if (state_a !== ((e == rel) ? 2'd2 : 2'd1)) begin
          errors++;
          $display("FAIL glitch_state g=%0d w=%0d edge %0d: got %0d required %0d", g, w, e, state_a, (e == rel) ? 2 : 1);
        end
      end
    end
    checks++;
    if (cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL glitch_count: got %0d required 0", cnt_a);
    end
  endtask

  task automatic test_lock_loss_run();
    int n;
    locked_in = 1'b1;
    do_reset();
    n = 0;
    while (state_a !== 2'd3 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (state_a !== 2'd3) begin
      errors++;
      $display("FAIL loss_reach_run: got state %0d required 3 within 300 cycles", state_a);
      return;
    end
    repeat ($urandom_range(0, 5)) @(negedge clk);
    locked_in = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      checks++;
      if (j < 3 && (state_a !== 2'd3 || rst_a !== 4'hF)) begin
        errors++;
        $display("FAIL loss_sync_delay edge+%0d: st=%0d rst=%b required 3/1111", j, state_a, rst_a);
      end else if (j == 3 && (state_a !== 2'd0 || rst_a !== 4'h0 || done_a !== 1'b0 || cnt_a !== 8'd1)) begin
        errors++;
        $display("FAIL loss_assert: st=%0d rst=%b done=%b cnt=%0d required 0/0000/0/1", state_a, rst_a, done_a, cnt_a);
      end
    end
    locked_in = 1'b1;
    for (int h = 1; h <= 106; h++) begin
      @(negedge clk);
      if (h == 17 || h == 81 || h == 106) begin
        checks++;
        if (state_a !== ((h == 17) ? 2'd1 : (h == 81) ? 2'd2 : 2'd3)) begin
          errors++;
          $display("FAIL loss_resequence +%0d: got state %0d", h, state_a);
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    checks++;
    if (state_a !== 2'd0 || rst_a !== 4'h0 || done_a !== 1'b0 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL sw_assert: st=%0d rst=%b done=%b cnt=%0d required 0/0000/0/1", state_a, rst_a, done_a, cnt_a);
    end
    for (int h = 1; h <= 81; h++) begin
      @(negedge clk);
      if (h == 17 || h == 80 || h == 81) begin
        checks++;
        if (state_a !== ((h == 81) ? 2'd2 : 2'd1)) begin
          errors++;
          $display("FAIL sw_resequence +%0d: got state %0d", h, state_a);
        end
      end
    end
  endtask

  task automatic test_cnt_saturate();
    int exp_z[5] = '{1, 2, 3, 3, 3};
    int n;
    locked_in = 1'b1;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (state_z !== 2'd3 && n < 300) begin @(negedge clk); n++; end
      locked_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (cnt_z !== 2'(exp_z[j]) || cnt_a !== 8'(j + 1)) begin
        errors++;
        $display("FAIL sat_count loss %0d: cnt_z=%0d cnt_a=%0d required %0d/%0d", j + 1, cnt_z, cnt_a, exp_z[j], j + 1);
      end
      locked_in = 1'b1;
    end
  endtask

  task automatic test_rst_mid_release();
    int n;
    n = 0;
    while (!(state_a === 2'd2 && rst_a === 4'b0011) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (rst_a !== 4'b0011) begin
      errors++;
      $display("FAIL mid_reach: rst=%b required 0011 within 300 cycles", rst_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rst_a !== 4'h0 || state_a !== 2'd0 || done_a !== 1'b0 || cnt_a !== 8'd0 || rst_z !== 4'h0 || cnt_z !== 2'd0) begin
      errors++;
      $display("FAIL mid_async: rst_a=%b st=%0d done=%b cnt_a=%0d rst_z=%b cnt_z=%0d required all zero",
               rst_a, state_a, done_a, cnt_a, rst_z, cnt_z);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stagger_zero();
    locked_in = 1'b1;
    do_reset();
    for (int e = 0; e <= 81; e++) begin
      @(negedge clk);
      if (e == 79 || e == 80) begin
        checks++;
        if (rst_z !== ((e == 80) ? 4'hF : 4'h0) || (e == 80 && (state_z !== 2'd2 || rst_a !== 4'b0001))) begin
          errors++;
          $display("FAIL zero_release edge %0d: rst_z=%b st_z=%0d rst_a=%b", e, rst_z, state_z, rst_a);
        end
      end
      if (e == 81) begin
        checks++;
        if (state_z !== 2'd3 || done_z !== 1'b1) begin
          errors++;
          $display("FAIL zero_run: st=%0d done=%b required 3/1", state_z, done_z);
        end
      end
    end
  endtask

  task automatic test_random_soak();
    int lo_left, sw_left;
    lo_left = 0; sw_left = 0;
    locked_in = 1'b1; sw_rst_req = 1'b0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (lo_left > 0) lo_left--;
      else if ($urandom_range(0, 299) == 0) lo_left = $urandom_range(1, 8);
      if (sw_left > 0) sw_left--;
      else if ($urandom_range(0, 599) == 0) sw_left = $urandom_range(1, 4);
      locked_in = (lo_left == 0);
      sw_rst_req = (sw_left != 0);
      @(negedge clk);
    end
    locked_in = 1'b1; sw_rst_req = 1'b0;
    checks++;
    if (cnt_a !== 8'(m_cnt[0]) || cnt_z !== 2'(m_cnt[1])) begin
      errors++;
      $display("FAIL soak_count: cnt_a=%0d cnt_z=%0d required %0d/%0d", cnt_a, cnt_z, m_cnt[0], m_cnt[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_default_sequence();
    test_lock_glitch();
    test_lock_loss_run();
    test_sw_reset();
    test_cnt_saturate();
    test_rst_mid_release();
    test_stagger_zero();
    test_random_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
